// File: rtl/gmii_rx_fcs_checker.sv
// GMII receive front end: strips the preamble and SFD, forwards frame octets
// with a fixed 2-cycle latency, checks the CRC-32 and keeps per-category frame counters.
module gmii_rx_fcs_checker #(
  parameter int unsigned C_MIN_FRAME_SIZE = 64,
  parameter int unsigned C_MAX_PREAMBLE   = 15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_d,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic        stats_clear,
  output logic [7:0]  gmii_d,
  output logic        gmii_en,
  output logic        gmii_er,
  output logic        frame_done,
  output logic        frame_bad,
  output logic [31:0] cnt_ok,
  output logic [31:0] cnt_fcs_err,
  output logic [31:0] cnt_runt,
  output logic [31:0] cnt_rx_err,
  output logic [31:0] cnt_align_err
);

  localparam int unsigned PRE_W = $clog2(C_MAX_PREAMBLE + 2);
  localparam int unsigned LEN_W = 16;
  localparam int unsigned CNT_W = 32;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [7:0]  OCT_PRE     = 8'h55;
  localparam logic [7:0]  OCT_SFD     = 8'hD5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               rx_dv_q;
  logic [PRE_W-1:0]   pre_cnt_q;
  logic [31:0]        crc_q;
  logic [LEN_W-1:0]   len_q;
  logic               err_q;
  logic [7:0]         s1_d;
  logic               s1_en;
  logic               s1_er;

  logic               sfd_c;
  logic               pre_start_c;
  logic               pre_inc_c;
  logic               align_inc_c;
  logic               data_c;
  logic               end_c;
  logic               runt_c;
  logic               crc_bad_c;
  logic               bad_c;
  logic [31:0]        crc_next_c;

  // Reflected CRC-32 update over one octet, LSB first
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: preamble/SFD delineation
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_dv && !rx_dv_q) begin
          if (rx_d == OCT_PRE)      state_d = ST_PREAMBLE;
          else if (rx_d == OCT_SFD) state_d = ST_DATA;
          else                      state_d = ST_DROP;
        end
      end
      ST_PREAMBLE: begin
        if (!rx_dv)                                           state_d = ST_IDLE;
        else if (rx_d == OCT_PRE && 32'(pre_cnt_q) >= C_MAX_PREAMBLE) state_d = ST_DROP;
        else if (rx_d == OCT_PRE)                             state_d = ST_PREAMBLE;
        else if (rx_d == OCT_SFD)                             state_d = ST_DATA;
        else                                                  state_d = ST_DROP;
      end
      ST_DATA: if (!rx_dv) state_d = ST_IDLE;
      ST_DROP: if (!rx_dv) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/strobe decode from the current and next state
  always_comb begin
    sfd_c       = 1'b0;
    pre_start_c = 1'b0;
    pre_inc_c   = 1'b0;
    align_inc_c = 1'b0;
    data_c      = 1'b0;
    end_c       = 1'b0;
    sfd_c       = (state_d == ST_DATA) && (state_q != ST_DATA);
    pre_start_c = (state_q == ST_IDLE) && (state_d == ST_PREAMBLE);
    pre_inc_c   = (state_q == ST_PREAMBLE) && (state_d == ST_PREAMBLE);
    align_inc_c = ((state_d == ST_DROP) && (state_q != ST_DROP)) ||
                  ((state_q == ST_PREAMBLE) && !rx_dv);
    data_c      = (state_q == ST_DATA) && rx_dv;
    end_c       = (state_q == ST_DATA) && !rx_dv;
  end

  // End-of-frame classification, valid while end_c is high
  always_comb begin
    crc_next_c = crc_byte(crc_q, rx_d);
    runt_c     = 32'(len_q) < C_MIN_FRAME_SIZE;
    crc_bad_c  = crc_q != CRC_RESIDUE;
    bad_c      = err_q || runt_c || crc_bad_c;
  end

  // Frame accumulators, stage-1 capture and output stage
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_dv_q    <= rx_dv;
      pre_cnt_q  <= '0;
      crc_q      <= CRC_INIT;
      len_q      <= '0;
      err_q      <= 1'b0;
      s1_d       <= '0;
      s1_en      <= 1'b0;
      s1_er      <= 1'b0;
      gmii_d     <= '0;
      gmii_en    <= 1'b0;
      gmii_er    <= 1'b0;
      frame_done <= 1'b0;
      frame_bad  <= 1'b0;
    end else begin
      rx_dv_q <= rx_dv;
      if (pre_start_c)    pre_cnt_q <= PRE_W'(1);
      else if (pre_inc_c) pre_cnt_q <= PRE_W'(pre_cnt_q + 1'b1);
      if (sfd_c) begin
        crc_q <= CRC_INIT;
        len_q <= '0;
        err_q <= 1'b0;
      end else if (data_c) begin
        crc_q <= crc_next_c;
        if (len_q != '1) len_q <= LEN_W'(len_q + 1'b1);
        if (rx_er)       err_q <= 1'b1;
      end
      s1_en      <= data_c;
      s1_d       <= data_c ? rx_d : 8'h00;
      s1_er      <= data_c && rx_er;
      gmii_d     <= s1_d;
      gmii_en    <= s1_en;
      gmii_er    <= s1_er || (end_c && s1_en && bad_c);
      frame_done <= end_c && s1_en;
      frame_bad  <= end_c && s1_en && bad_c;
    end
  end

  // Frame counters; a clear wins over a coincident increment
  always_ff @(posedge clk) begin
    if (!resetn || stats_clear) begin
      cnt_ok        <= '0;
      cnt_fcs_err   <= '0;
      cnt_runt      <= '0;
      cnt_rx_err    <= '0;
      cnt_align_err <= '0;
    end else begin
      if (end_c && err_q)                            cnt_rx_err  <= CNT_W'(cnt_rx_err + 1'b1);
      if (end_c && !err_q && runt_c)                 cnt_runt    <= CNT_W'(cnt_runt + 1'b1);
      if (end_c && !err_q && !runt_c && crc_bad_c)   cnt_fcs_err <= CNT_W'(cnt_fcs_err + 1'b1);
      if (end_c && !bad_c)                           cnt_ok      <= CNT_W'(cnt_ok + 1'b1);
      if (align_inc_c)                               cnt_align_err <= CNT_W'(cnt_align_err + 1'b1);
    end
  end

endmodule

// File: tb/tb_gmii_rx_fcs_checker.sv
// Scoreboard bench for gmii_rx_fcs_checker: directed frames, queued expectations,
// negedge monitor comparing forwarded octets, idle output and counters.
module tb_gmii_rx_fcs_checker;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  rx_d;
  logic        rx_dv;
  logic        rx_er;
  logic        stats_clear;
  logic [7:0]  gmii_d;
  logic        gmii_en;
  logic        gmii_er;
  logic        frame_done;
  logic        frame_bad;
  logic [31:0] cnt_ok;
  logic [31:0] cnt_fcs_err;
  logic [31:0] cnt_runt;
  logic [31:0] cnt_rx_err;
  logic [31:0] cnt_align_err;

  gmii_rx_fcs_checker #(.C_MIN_FRAME_SIZE(64), .C_MAX_PREAMBLE(15)) dut (
    .clk(clk), .resetn(resetn), .rx_d(rx_d), .rx_dv(rx_dv), .rx_er(rx_er),
    .stats_clear(stats_clear), .gmii_d(gmii_d), .gmii_en(gmii_en), .gmii_er(gmii_er),
    .frame_done(frame_done), .frame_bad(frame_bad), .cnt_ok(cnt_ok),
    .cnt_fcs_err(cnt_fcs_err), .cnt_runt(cnt_runt), .cnt_rx_err(cnt_rx_err),
    .cnt_align_err(cnt_align_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       er;
    logic       done;
    logic       bad;
    int         stamp;
  } exp_t;

  typedef struct {
    int               id;
    logic [4:0][31:0] v;
  } cnt_exp_t;

  exp_t       sb[$];
  cnt_exp_t   cq[$];
  logic [7:0] wire_q[$];
  logic       wire_er[$];
  logic [7:0] pay[$];

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic mon_on = 1'b0;
  logic fin = 1'b0;
  exp_t e;
  cnt_exp_t ce;

  always @(posedge clk) cyc <= cyc + 1;

  // Bit-serial IEEE 802.3 CRC over pay[], returned as the FCS to transmit
  function automatic logic [31:0] fcs_of();
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    foreach (pay[j]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ pay[j][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  // Build preamble + SFD + ndata zero octets + FCS; optional bit flip and rx_er position
  task automatic mk_frame(input int npre, input int ndata, input int flip_at, input int er_at);
    logic [31:0] fcs;
    wire_q.delete(); wire_er.delete(); pay.delete();
    for (int i = 0; i < ndata; i++) pay.push_back(8'h00);
    fcs = fcs_of();
    for (int k = 0; k < 4; k++) pay.push_back(fcs[8*k +: 8]);
    if (flip_at >= 0) pay[flip_at] = pay[flip_at] ^ 8'h01;
    for (int i = 0; i < npre; i++) begin wire_q.push_back(8'h55); wire_er.push_back(1'b0); end
    wire_q.push_back(8'hD5); wire_er.push_back(1'b0);
    foreach (pay[i]) begin
      wire_q.push_back(pay[i]);
      wire_er.push_back(i == er_at);
    end
  endtask

  // Drive wire_q; queue expectations for octets from index fwd (-1: none forwarded)
  task automatic send_wire(input int fwd, input logic exp_bad, input int rst_idx, input logic clr);
    exp_t x;
    logic last;
    for (int i = 0; i < wire_q.size(); i++) begin
      @(posedge clk); #1;
      rx_dv  = 1'b1;
      rx_d   = wire_q[i];
      rx_er  = wire_er[i];
      resetn = (i != rst_idx);
      if (fwd >= 0 && i >= fwd && (rst_idx < 0 || i <= rst_idx - 2)) begin
        last    = (i == wire_q.size() - 1) && (rst_idx < 0);
        x.d     = wire_q[i];
        x.er    = wire_er[i] | (last & exp_bad);
        x.done  = last;
        x.bad   = last & exp_bad;
        x.stamp = cyc + 2;
        sb.push_back(x);
      end
    end
    @(posedge clk); #1;
    rx_dv = 1'b0; rx_d = 8'h00; rx_er = 1'b0; resetn = 1'b1; stats_clear = clr;
    @(posedge clk); #1;
    stats_clear = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic expect_cnts(input int id, input logic [31:0] ok, input logic [31:0] fcs,
                             input logic [31:0] runt, input logic [31:0] rxe, input logic [31:0] aln);
    cnt_exp_t c;
    c.id = id;
    c.v  = {ok, fcs, runt, rxe, aln};
    cq.push_back(c);
  endtask

  // Monitor: sole checker, runs on the falling edge
  always @(negedge clk) begin
    if (mon_on) begin
      vectors = vectors + 1;
      if (gmii_en || frame_done) begin
        if (sb.size() == 0) begin
          miscompares = miscompares + 1;
          $display("FAIL unexpected_octet cyc=%0d: got d=%h en=%b er=%b done=%b, required no output",
                   cyc, gmii_d, gmii_en, gmii_er, frame_done);
        end else begin
          e = sb.pop_front();
          if (gmii_d !== e.d || gmii_er !== e.er || frame_done !== e.done ||
              frame_bad !== e.bad || gmii_en !== 1'b1 || cyc != e.stamp) begin
            miscompares = miscompares + 1;
            $display("FAIL octet: got d=%h en=%b er=%b done=%b bad=%b cyc=%0d, required d=%h en=1 er=%b done=%b bad=%b cyc=%0d",
                     gmii_d, gmii_en, gmii_er, frame_done, frame_bad, cyc, e.d, e.er, e.done, e.bad, e.stamp);
          end
        end
      end else if (gmii_d !== 8'h00 || gmii_er !== 1'b0 || frame_bad !== 1'b0) begin
        miscompares = miscompares + 1;
        $display("FAIL idle_out cyc=%0d: got d=%h er=%b bad=%b, required 00/0/0",
                 cyc, gmii_d, gmii_er, frame_bad);
      end
      if (cq.size() != 0) begin
        ce = cq.pop_front();
        vectors = vectors + 1;
        if ({cnt_ok, cnt_fcs_err, cnt_runt, cnt_rx_err, cnt_align_err} !== ce.v) begin
          miscompares = miscompares + 1;
          $display("FAIL counters#%0d: got ok=%0d fcs=%0d runt=%0d rxe=%0d aln=%0d, required ok=%0d fcs=%0d runt=%0d rxe=%0d aln=%0d",
                   ce.id, cnt_ok, cnt_fcs_err, cnt_runt, cnt_rx_err, cnt_align_err,
                   ce.v[4], ce.v[3], ce.v[2], ce.v[1], ce.v[0]);
        end
      end
      if (fin) begin
        vectors = vectors + 1;
        if (sb.size() != 0) begin
          miscompares = miscompares + 1;
          $display("FAIL missing_octets: got %0d expected octets never seen, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
      end
    end
  end

  initial begin
    resetn = 1'b0; rx_d = 8'h00; rx_dv = 1'b0; rx_er = 1'b0; stats_clear = 1'b0;
    @(posedge clk); #1;
    mon_on = 1'b1;
    expect_cnts(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Good 64-octet frame
    mk_frame(7, 60, -1, -1);
    send_wire(8, 1'b0, -1, 1'b0);
    expect_cnts(1, 1, 0, 0, 0, 0);

    // Payload bit flipped: FCS error
    mk_frame(7, 60, 5, -1);
    send_wire(8, 1'b1, -1, 1'b0);
    expect_cnts(2, 1, 1, 0, 0, 0);

    // 44-octet frame with valid FCS: runt
    mk_frame(7, 40, -1, -1);
    send_wire(8, 1'b1, -1, 1'b0);
    expect_cnts(3, 1, 1, 1, 0, 0);

    // rx_er on data octet 10 of a good frame
    mk_frame(7, 60, -1, 9);
    send_wire(8, 1'b1, -1, 1'b0);
    expect_cnts(4, 1, 1, 1, 1, 0);

    // 16-octet preamble: overlong, nothing forwarded
    wire_q.delete(); wire_er.delete();
    for (int i = 0; i < 16; i++) begin wire_q.push_back(8'h55); wire_er.push_back(1'b0); end
    wire_q.push_back(8'hD5); wire_er.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin wire_q.push_back(8'h00); wire_er.push_back(1'b0); end
    send_wire(-1, 1'b0, -1, 1'b0);
    expect_cnts(5, 1, 1, 1, 1, 1);

    // Bad SFD after two preamble octets
    wire_q.delete(); wire_er.delete();
    wire_q.push_back(8'h55); wire_q.push_back(8'h55); wire_q.push_back(8'hAB);
    for (int i = 0; i < 3; i++) wire_er.push_back(1'b0);
    for (int i = 0; i < 5; i++) begin wire_q.push_back(8'h00); wire_er.push_back(1'b0); end
    send_wire(-1, 1'b0, -1, 1'b0);
    expect_cnts(6, 1, 1, 1, 1, 2);

    // Reset during data octet 30, rx_dv held high to frame end
    mk_frame(7, 60, -1, -1);
    send_wire(8, 1'b0, 8 + 29, 1'b0);
    expect_cnts(7, 0, 0, 0, 0, 0);

    // Next good frame after the reset is counted
    mk_frame(7, 60, -1, -1);
    send_wire(8, 1'b0, -1, 1'b0);
    expect_cnts(8, 1, 0, 0, 0, 0);

    // Short preamble (SFD first) with stats_clear coincident with frame_done
    mk_frame(0, 60, -1, -1);
    send_wire(1, 1'b0, -1, 1'b1);
    expect_cnts(9, 0, 0, 0, 0, 0);

    repeat (4) @(posedge clk);
    #1;
    fin = 1'b1;
  end

endmodule
